inst_sequencer: RTL
===================

// Module: inst_sequencer
// PURPOSE
//  Issuing side of the 12-bit inst/inst_en device-control interface. Holds a small
//  program loaded through a write port and, on start, streams instructions to a
//  downstream device (register bank, etc.) with programmable waits and one loop
//  level. Sits between the host/test controller and a single instruction-driven device.
// PARAMETERS
//  ADDR_W  4  program address width; program depth = 2**ADDR_W words
// PORTS
//  clock      in   1       system clock, all logic on rising edge
//  reset      in   1       synchronous, active-high reset
//  prog_addr  in   ADDR_W  program write address
//  prog_data  in   16      program word to write
//  prog_we    in   1       program write strobe (honoured only in Idle)
//  start      in   1       begin execution at address 0 (honoured only in Idle)
//  stop       in   1       abort execution (honoured only in Run/Wait)
//  inst       out  12      instruction to device
//  inst_en    out  1       inst valid, one cycle per emitted instruction
//  busy       out  1       high in Run/Wait
//  done       out  1       one-cycle pulse when HALT executes
//  error      out  1       high in Error state (sticky until reset)
// BEHAVIOUR
//  Program word: [15:14] op, [13:12] reserved (must be 0), [11:0] operand.
//   op 00 EMIT: inst <= [11:0]; op 01 WAIT: n = [7:0];
//   op 10 LOOP: target = [ADDR_W-1:0], count = [11:8]; op 11 HALT.
//  Memory: write-only port, combinational read at pc; contents NOT cleared by reset.
//  All outputs registered. Reset values: inst=0, inst_en=0, busy=0, done=0, error=0,
//   pc=0, loop disarmed, state=Reset.
//  States: Reset -> Idle (next cycle, unconditional). Idle -> Run on start (pc<=0,
//   loop disarmed). Run executes one word per cycle. Run -> Wait on WAIT n>0.
//   Wait -> Run after n cycles. Run -> Idle on HALT. Run/Wait -> Idle on stop.
//   Run -> Error on reserved bits != 0. Error holds until reset.
//  EMIT at cycle t: inst=operand, inst_en=1 during cycle t+1 only; back-to-back EMITs
//   give contiguous inst_en. inst keeps last value when inst_en=0.
//  WAIT n: occupies 1+n cycles total; n=0 acts as 1-cycle NOP. pc+1 afterwards.
//  LOOP: not armed & count=0 -> fall through. Not armed & count>0 -> arm, cnt<=count-1,
//   jump to target. Armed & cnt>0 -> cnt-1, jump. Armed & cnt=0 -> disarm, fall through.
//   Body therefore runs count+1 times. No nesting: inner LOOP shares the counter.
//  pc increments modulo 2**ADDR_W (wraps last address -> 0).
//  HALT: done=1 for exactly the following cycle; busy drops the same cycle.
//  stop in Run/Wait: wins over the current word (word not executed), Idle next cycle,
//   no done pulse, inst_en=0. stop in Idle/Error ignored.
//  start in Run/Wait/Error ignored; start & stop together in Idle -> start.
//  prog_we outside Idle dropped (memory unchanged).
//  Error: inst_en=0, busy=0, error=1; start/prog_we ignored.
//  Reset mid-run: all registers to reset values next cycle; memory retained.
// TESTING
//  1. Load EMIT 0x2AB, EMIT 0x102, HALT; start -> inst_en high 2 consecutive cycles
//     (0x2AB then 0x102), done pulses 1 cycle, busy low, inst stays 0x102.
//  2. EMIT 0x201, WAIT 3, EMIT 0x202, HALT -> two inst_en pulses separated by
//     exactly 4 low cycles.
//  3. EMIT 0x301 @0, LOOP tgt 0 cnt 2 @1, HALT @2 -> exactly 3 pulses of 0x301, then done;
//     rerun with cnt 0 -> exactly 1 pulse.
//  4. Word 0x1005 (reserved=01) @0; start -> error=1 next cycle, no inst_en; start
//     ignored; reset -> error=0, Idle.
//  5. EMIT 0x210, WAIT 200; stop during wait -> busy low next cycle, no done, no
//     further inst_en; start replays from address 0 (0x210 re-emitted).
//  6. Reset during a running loop -> outputs at reset values, loop disarmed;
//     prog_we while busy leaves memory unchanged; pc wrap 15->0 with ADDR_W=4.

Source files
------------

// File: rtl/inst_sequencer_if.sv
// Host-side bus of the instruction sequencer: program load port, run control
// and the 12-bit inst/inst_en device-control stream with status flags.
interface inst_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              prog_we;
    logic              start;
    logic              stop;
    logic [11:0]       inst;
    logic              inst_en;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output prog_addr, prog_data, prog_we, start, stop,
        input  inst, inst_en, busy, done, error
    );

    modport slave (
        input  prog_addr, prog_data, prog_we, start, stop,
        output inst, inst_en, busy, done, error
    );
endinterface

// File: rtl/inst_sequencer.sv
// Small program store plus a one-word-per-cycle executor that streams EMIT
// operands onto inst/inst_en, with WAIT delays, one loop level and HALT.
module inst_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    inst_sequencer_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_ERROR
    } state_t;

    localparam logic [1:0] OP_EMIT = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_LOOP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic [15:0]       mem [DEPTH];
    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              armed_reg;
    logic [3:0]        loop_cnt_reg;
    logic [7:0]        wait_cnt_reg;
    logic [11:0]       inst_reg;
    logic              inst_en_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;

    logic [15:0]       word;
    logic [1:0]        word_op;
    logic [ADDR_W-1:0] pc_inc;

    // Program memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clock) begin
        if (bus.prog_we && state_reg == ST_IDLE) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign word    = mem[pc_reg];
    assign word_op = word[15:14];
    assign pc_inc  = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_RESET;
            pc_reg       <= '0;
            armed_reg    <= 1'b0;
            loop_cnt_reg <= 4'd0;
            wait_cnt_reg <= 8'd0;
            inst_reg     <= 12'd0;
            inst_en_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            inst_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                ST_RESET: state_reg <= ST_IDLE;
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg <= ST_RUN;
                        pc_reg    <= '0;
                        armed_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // stop pre-empts the word at pc: it is not executed
                    if (bus.stop) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (word[13:12] != 2'b00) begin
                        state_reg <= ST_ERROR;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                    end else begin
                        case (word_op)
                            OP_EMIT: begin
                                inst_reg    <= word[11:0];
                                inst_en_reg <= 1'b1;
                                pc_reg      <= pc_inc;
                            end
                            OP_WAIT: begin
                                pc_reg <= pc_inc;
                                if (word[7:0] != 8'd0) begin
                                    state_reg    <= ST_WAIT;
                                    wait_cnt_reg <= word[7:0];
                                end
                            end
                            OP_LOOP: begin
                                if (!armed_reg) begin
                                    if (word[11:8] == 4'd0) begin
                                        pc_reg <= pc_inc;
                                    end else begin
                                        armed_reg    <= 1'b1;
                                        loop_cnt_reg <= word[11:8] - 4'd1;
                                        pc_reg       <= word[ADDR_W-1:0];
                                    end
                                end else if (loop_cnt_reg != 4'd0) begin
                                    loop_cnt_reg <= loop_cnt_reg - 4'd1;
                                    pc_reg       <= word[ADDR_W-1:0];
                                end else begin
                                    armed_reg <= 1'b0;
                                    pc_reg    <= pc_inc;
                                end
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (bus.stop) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (wait_cnt_reg == 8'd1) begin
                        state_reg <= ST_RUN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 8'd1;
                    end
                end
                ST_ERROR: state_reg <= ST_ERROR;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.inst    = inst_reg;
    assign bus.inst_en = inst_en_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.error   = error_reg;
endmodule
